// File: rtl/isa_pkg.sv
// ISA constants shared by the sequencer: opcodes, instruction field positions, FSM states.
package isa_pkg;

    localparam int DATA_W = 16;

    // Instruction field bit positions: op=[15:12], rx=[11:9], ry=[8:6]
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RX_HI = 11;
    localparam int RX_LO = 9;
    localparam int RY_HI = 8;
    localparam int RY_LO = 6;
    localparam int FIELD_W = RX_HI - RX_LO + 1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MV   = 4'h1;
    localparam logic [3:0] OP_MVI  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_PUSH = 4'h7;
    localparam logic [3:0] OP_POP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        S_FETCH0,
        S_FETCH1,
        S_DECODE,
        S_E1,
        S_E2,
        S_E3,
        S_E4,
        S_E5,
        S_HALT
    } state_t;

    // ADD/SUB/XOR share one three-step execute sequence
    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder with enable; all outputs low when disabled.
module onehot_dec #(
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            // Each output compares the select against its own index
            assign onehot[gi] = en && (sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/instr_sequencer.sv
// Microsequencer for the single-bus CPU: fetch, decode and execute sequencing
// with all bus-drive and load strobes decoded from the current state (Moore).
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int DATA_W    = isa_pkg::DATA_W,
    parameter int NREG      = 8,
    parameter int STACK_REG = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] instr,
    output logic [NREG-1:0]   rin,
    output logic [NREG-1:0]   rout,
    output logic              gin,
    output logic              gout,
    output logic              a_in,
    output logic              addsub,
    output logic              xorctrl,
    output logic              pcin,
    output logic              pc_inc,
    output logic              pcout,
    output logic              ram_out,
    output logic              wren,
    output logic              stack_sel,
    output logic              instr_ctrl,
    output logic              ctrl_out,
    output logic [DATA_W-1:0] cu_out,
    output logic              new_instr,
    output logic              halted
);

    localparam logic [FIELD_W-1:0] SP_IDX = FIELD_W'(STACK_REG);

    state_t state_reg, state_next;

    logic [3:0]         op;
    logic [FIELD_W-1:0] rx, ry;
    logic               rin_en, rout_en;
    logic [FIELD_W-1:0] rin_sel, rout_sel;

    assign op = instr[OP_HI:OP_LO];
    assign rx = instr[RX_HI:RX_LO];
    assign ry = instr[RY_HI:RY_LO];

    // State register; reset returns to FETCH0 from anywhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_FETCH0;
        else     state_reg <= state_next;
    end

    // Next-state and strobe decode from state and IR opcode
    always_comb begin
        state_next = state_reg;
        rin_en     = 1'b0;
        rin_sel    = '0;
        rout_en    = 1'b0;
        rout_sel   = '0;
        gin        = 1'b0;
        gout       = 1'b0;
        a_in       = 1'b0;
        addsub     = 1'b0;
        xorctrl    = 1'b0;
        pcin       = 1'b0;
        pc_inc     = 1'b0;
        pcout      = 1'b0;
        ram_out    = 1'b0;
        wren       = 1'b0;
        stack_sel  = 1'b0;
        instr_ctrl = 1'b0;
        ctrl_out   = 1'b0;
        cu_out     = '0;
        new_instr  = 1'b0;
        halted     = 1'b0;
        case (state_reg)
            S_FETCH0: begin
                // RAM address is PC; read data is valid next cycle
                if (run) state_next = S_FETCH1;
            end
            S_FETCH1: begin
                ram_out    = 1'b1;
                instr_ctrl = 1'b1;
                pc_inc     = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                new_instr = 1'b1;
                if (op == OP_HALT)
                    state_next = S_HALT;
                else if ((op >= OP_MV) && (op <= OP_POP))
                    state_next = S_E1;
                else
                    state_next = S_FETCH0;
            end
            S_E1: begin
                state_next = S_E2;
                if (op == OP_MV) begin
                    rout_en = 1'b1; rout_sel = ry;
                    rin_en  = 1'b1; rin_sel  = rx;
                    state_next = S_FETCH0;
                end else if (is_alu(op)) begin
                    rout_en = 1'b1; rout_sel = rx;
                    a_in    = 1'b1;
                end else if (op == OP_JMP) begin
                    rout_en = 1'b1; rout_sel = rx;
                    pcin    = 1'b1;
                    state_next = S_FETCH0;
                end else if (op == OP_PUSH) begin
                    rout_en = 1'b1; rout_sel = SP_IDX;
                    a_in    = 1'b1;
                end else if (op == OP_POP) begin
                    stack_sel = 1'b1;
                end
                // MVI: address stays on PC while the immediate is read
            end
            S_E2: begin
                state_next = S_E3;
                if (op == OP_MVI) begin
                    ram_out = 1'b1;
                    rin_en  = 1'b1; rin_sel = rx;
                    pc_inc  = 1'b1;
                    state_next = S_FETCH0;
                end else if (is_alu(op)) begin
                    rout_en = 1'b1; rout_sel = ry;
                    gin     = 1'b1;
                    addsub  = (op == OP_SUB);
                    xorctrl = (op == OP_XOR);
                end else if (op == OP_PUSH) begin
                    ctrl_out = 1'b1;
                    cu_out   = DATA_W'(1);
                    gin      = 1'b1;
                    addsub   = 1'b1;
                end else begin
                    stack_sel = 1'b1;
                    ram_out   = 1'b1;
                    rin_en    = 1'b1; rin_sel = rx;
                end
            end
            S_E3: begin
                state_next = S_E4;
                if (is_alu(op)) begin
                    gout   = 1'b1;
                    rin_en = 1'b1; rin_sel = rx;
                    state_next = S_FETCH0;
                end else if (op == OP_PUSH) begin
                    gout   = 1'b1;
                    rin_en = 1'b1; rin_sel = SP_IDX;
                end else begin
                    rout_en = 1'b1; rout_sel = SP_IDX;
                    a_in    = 1'b1;
                end
            end
            S_E4: begin
                if (op == OP_PUSH) begin
                    stack_sel = 1'b1;
                    rout_en   = 1'b1; rout_sel = rx;
                    wren      = 1'b1;
                    state_next = S_FETCH0;
                end else begin
                    ctrl_out = 1'b1;
                    cu_out   = DATA_W'(1);
                    gin      = 1'b1;
                    state_next = S_E5;
                end
            end
            S_E5: begin
                gout   = 1'b1;
                rin_en = 1'b1; rin_sel = SP_IDX;
                state_next = S_FETCH0;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_next = S_FETCH0;
        endcase
    end

    onehot_dec #(.N(NREG), .SEL_W(FIELD_W)) u_rin_dec (
        .en     (rin_en),
        .sel    (rin_sel),
        .onehot (rin)
    );

    onehot_dec #(.N(NREG), .SEL_W(FIELD_W)) u_rout_dec (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (rout)
    );

    // Bus-safety invariants
    a_one_driver: assert property (@(posedge clk) disable iff (rst)
        $onehot0({|rout, $onehot0(rout) ? 1'b0 : 1'b1, gout, pcout, ram_out, ctrl_out}) && $onehot0(rout));
    a_rin_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rin));
    a_wren_stack: assert property (@(posedge clk) disable iff (rst) wren |-> stack_sel);
    a_cu_out:     assert property (@(posedge clk) disable iff (rst) (cu_out != '0) |-> ctrl_out);

endmodule
